// File: rtl/regfile_wb_seq_pkg.sv
// Shared types and constants for the register-file writeback sequencer.
// Holds the FSM state encoding and the fixed init-register indices.
package regfile_wb_seq_pkg;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned DataW   = 32;
    localparam int unsigned NumRegs = 1 << RegIdxW;

    typedef logic [RegIdxW-1:0] reg_idx_t;
    typedef logic [DataW-1:0]   reg_data_t;

    localparam reg_idx_t RegZero = 5'd0;
    localparam reg_idx_t RegSp   = 5'd2;
    localparam reg_idx_t RegBp   = 5'd8;

    typedef enum logic [1:0] {
        StInitSp,
        StInitBp,
        StRun
    } state_e;

endpackage

// File: rtl/regfile_wb_seq_if.sv
// Writeback request bus: NREQ requesters, each offering (rd, data) under valid/ready.
// The master side drives requests; the sequencer (slave) returns the grants.
interface regfile_wb_seq_if
    import regfile_wb_seq_pkg::*;
#(
    parameter int unsigned NREQ = 3
) ();

    logic [NREQ-1:0]         req_valid;
    logic [NREQ*RegIdxW-1:0] req_rd;
    logic [NREQ*DataW-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_seq_rr_arbiter.sv
// Round-robin arbiter with one-hot combinational grant.
// Search starts at the index after the last winner; the pointer resets to index 0.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         CLK,
    input  logic         RST_X,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] grant
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] win_idx;
    logic [N-1:0]    hi_req;
    logic [N-1:0]    sel_req;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest request.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = req[i] && (PtrW'(i) >= ptr_q);
        end
        sel_req = (|hi_req) ? hi_req : req;
        grant   = '0;
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel_req[i]) begin
                grant      = '0;
                grant[i]   = 1'b1;
                win_idx    = PtrW'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            ptr_q <= '0;
        end else if (update && (|grant)) begin
            ptr_q <= (win_idx == PtrW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_seq.sv
// Register-file writeback sequencer: initialises x2/x8, then arbitrates writeback
// requests round-robin and tracks pending writes for hazard detection.
module regfile_wb_seq
    import regfile_wb_seq_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter logic [31:0] SP_INIT = 32'hff00,
    parameter logic [31:0] BP_INIT = 32'hff00
) (
    input  logic              CLK,
    input  logic              RST_X,
    regfile_wb_seq_if.slave   wb,
    input  logic              iss_valid,
    input  reg_idx_t          iss_rd,
    input  reg_idx_t          q_rs1,
    input  reg_idx_t          q_rs2,
    output logic              hazard,
    output logic              wr_regfile,
    output reg_data_t         wr_regfile_data,
    output reg_idx_t          rd,
    output logic              init_done
);

    state_e               state_q;
    logic                 run;
    logic [NREQ-1:0]      req_masked;
    logic [NREQ-1:0]      grant;
    logic                 gnt_any;
    reg_idx_t             win_rd;
    reg_data_t            win_data;
    logic [NumRegs-1:0]   busy_q;
    logic [NumRegs-1:0]   busy_d;

    assign run        = (state_q == StRun);
    assign req_masked = run ? wb.req_valid : '0;
    assign gnt_any    = |grant;
    assign wb.req_ready = grant;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .CLK    (CLK),
        .RST_X  (RST_X),
        .req    (req_masked),
        .update (run),
        .grant  (grant)
    );

    always_comb begin
        win_rd   = RegZero;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_rd   = wb.req_rd[i*RegIdxW +: RegIdxW];
                win_data = wb.req_data[i*DataW +: DataW];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            state_q         <= StInitSp;
            wr_regfile      <= 1'b0;
            rd              <= RegZero;
            wr_regfile_data <= '0;
            init_done       <= 1'b0;
        end else begin
            case (state_q)
                StInitSp: begin
                    wr_regfile      <= 1'b1;
                    rd              <= RegSp;
                    wr_regfile_data <= SP_INIT;
                    state_q         <= StInitBp;
                end
                StInitBp: begin
                    wr_regfile      <= 1'b1;
                    rd              <= RegBp;
                    wr_regfile_data <= BP_INIT;
                    state_q         <= StRun;
                    init_done       <= 1'b1;
                end
                StRun: begin
                    // x0 writes are accepted from the requester but never reach the file.
                    wr_regfile <= gnt_any && (win_rd != RegZero);
                    if (gnt_any) begin
                        rd              <= win_rd;
                        wr_regfile_data <= win_data;
                    end
                end
                default: begin
                    wr_regfile <= 1'b0;
                    state_q    <= StInitSp;
                end
            endcase
        end
    end

    // Issue is applied after the clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[win_rd] = 1'b0;
        end
        if (run && iss_valid && (iss_rd != RegZero)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard = busy_q[q_rs1] | busy_q[q_rs2];

endmodule

// File: tb/tb_regfile_wb_seq.sv
// Directed bench for regfile_wb_seq: expected register writes go into a queue
// and an independent monitor checks each write's cycle, rd and data.
module tb_regfile_wb_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid;
    logic [4:0]  iss_rd, q_rs1, q_rs2;
    logic        hazard, wr_regfile, init_done;
    logic [31:0] wr_regfile_data;
    logic [4:0]  rd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_seq_if #(.NREQ(3)) wb ();

    regfile_wb_seq #(
        .NREQ    (3),
        .SP_INIT (32'hff00),
        .BP_INIT (32'hff00)
    ) dut (
        .CLK             (clk),
        .RST_X           (rst),
        .wb              (wb),
        .iss_valid       (iss_valid),
        .iss_rd          (iss_rd),
        .q_rs1           (q_rs1),
        .q_rs2           (q_rs2),
        .hazard          (hazard),
        .wr_regfile      (wr_regfile),
        .wr_regfile_data (wr_regfile_data),
        .rd              (rd),
        .init_done       (init_done)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_regfile) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_write: unexpected write cyc=%0d rd=%0d data=%h, none expected",
                         cyc, rd, wr_regfile_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rd !== rd || e.data !== wr_regfile_data) begin
                    n_fail++;
                    $display("FAIL wb_write: got cyc=%0d rd=%0d data=%h, expected cyc=%0d rd=%0d data=%h",
                             cyc, rd, wr_regfile_data, e.cyc, e.rd, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_at(input int c, input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{cyc: c, rd: r, data: d});
    endtask

    // Called during a grant cycle: the write lands after the next edge.
    task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
        push_at(cyc + 1, r, d);
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        wb.req_valid = v;
        wb.req_rd    = {r2, r1, r0};
        wb.req_data  = {d2, d1, d0};
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    logic [4:0]  rr_rd[3]   = '{5'd5, 5'd6, 5'd7};
    logic [31:0] rr_data[3] = '{32'h1111_0005, 32'h2222_0006, 32'h3333_0007};

    initial begin
        // Reset: drive activity that must be ignored.
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        q_rs1     = 5'd3;
        q_rs2     = 5'd0;
        set_req(3'b111, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h3);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr",        {31'b0, wr_regfile}, 32'h0);
        chk("rst_rd",        {27'b0, rd}, 32'h0);
        chk("rst_data",      wr_regfile_data, 32'h0);
        chk("rst_ready",     {29'b0, wb.req_ready}, 32'h0);
        chk("rst_hazard",    {31'b0, hazard}, 32'h0);
        chk("rst_init_done", {31'b0, init_done}, 32'h0);

        rst = 1'b0;
        push_at(1, 5'd2, 32'h0000ff00);
        push_at(2, 5'd8, 32'h0000ff00);
        nxt();
        chk("init_ready_c1", {29'b0, wb.req_ready}, 32'h0);
        chk("init_done_c1",  {31'b0, init_done}, 32'h0);
        chk("init_haz_c1",   {31'b0, hazard}, 32'h0);
        nxt();
        wb.req_valid = 3'b000;
        iss_valid    = 1'b0;
        #1;
        chk("init_iss_ignored", {31'b0, hazard}, 32'h0);
        nxt();
        chk("init_done_c3", {31'b0, init_done}, 32'h1);

        // Round robin with all three requesters valid.
        set_req(3'b111, rr_rd[0], rr_rd[1], rr_rd[2], rr_data[0], rr_data[1], rr_data[2]);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_grant%0d", k), {29'b0, wb.req_ready}, 32'(1 << (k % 3)));
            push_wr(rr_rd[k % 3], rr_data[k % 3]);
            nxt();
        end
        wb.req_valid = 3'b000;

        // Hazard set by issue, cleared by requester 1's writeback.
        iss_valid = 1'b1; iss_rd = 5'd9; q_rs1 = 5'd9; q_rs2 = 5'd0;
        #1;
        chk("haz_before_set", {31'b0, hazard}, 32'h0);
        nxt();
        iss_valid = 1'b0;
        #1;
        chk("haz_set", {31'b0, hazard}, 32'h1);
        set_req(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0000_9999, 32'h0);
        #1;
        chk("haz_grant1",    {29'b0, wb.req_ready}, 32'h2);
        chk("haz_no_bypass", {31'b0, hazard}, 32'h1);
        push_wr(5'd9, 32'h0000_9999);
        nxt();
        wb.req_valid = 3'b000;
        #1;
        chk("haz_cleared", {31'b0, hazard}, 32'h0);

        // Same-cycle issue and writeback of x4: issue wins.
        iss_valid = 1'b1; iss_rd = 5'd4; q_rs1 = 5'd0; q_rs2 = 5'd4;
        nxt();
        set_req(3'b001, 5'd4, 5'd0, 5'd0, 32'h4444_0000, 32'h0, 32'h0);
        #1;
        chk("iw_grant0", {29'b0, wb.req_ready}, 32'h1);
        chk("iw_haz_pre", {31'b0, hazard}, 32'h1);
        push_wr(5'd4, 32'h4444_0000);
        nxt();
        iss_valid = 1'b0;
        wb.req_valid = 3'b000;
        #1;
        chk("iw_issue_wins", {31'b0, hazard}, 32'h1);
        set_req(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0000_4444);
        #1;
        chk("iw_grant2", {29'b0, wb.req_ready}, 32'h4);
        push_wr(5'd4, 32'h0000_4444);
        nxt();
        wb.req_valid = 3'b000;
        #1;
        chk("iw_haz_cleared", {31'b0, hazard}, 32'h0);
        nxt();
        chk("hold_wr",   {31'b0, wr_regfile}, 32'h0);
        chk("hold_rd",   {27'b0, rd}, 32'h4);
        chk("hold_data", wr_regfile_data, 32'h0000_4444);

        // Writeback to x0 and issue to x0.
        set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hdeadbeef, 32'h0);
        iss_valid = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
        #1;
        chk("x0_grant1", {29'b0, wb.req_ready}, 32'h2);
        nxt();
        wb.req_valid = 3'b000;
        iss_valid    = 1'b0;
        #1;
        chk("x0_no_write", {31'b0, wr_regfile}, 32'h0);
        chk("x0_no_haz",   {31'b0, hazard}, 32'h0);

        // Two requesters to the same rd: both written in grant order.
        set_req(3'b011, 5'd12, 5'd12, 5'd0, 32'haaaa_0012, 32'hbbbb_0012, 32'h0);
        #1;
        chk("same_rd_g0", {29'b0, wb.req_ready}, 32'h1);
        push_wr(5'd12, 32'haaaa_0012);
        nxt();
        wb.req_valid = 3'b010;
        #1;
        chk("same_rd_g1", {29'b0, wb.req_ready}, 32'h2);
        push_wr(5'd12, 32'hbbbb_0012);
        nxt();
        wb.req_valid = 3'b000;

        // Reset right after a grant: pending state dropped, init repeats.
        iss_valid = 1'b1; iss_rd = 5'd10; q_rs1 = 5'd10; q_rs2 = 5'd0;
        nxt();
        iss_valid = 1'b0;
        #1;
        chk("mid_haz_set", {31'b0, hazard}, 32'h1);
        set_req(3'b100, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'h1313_1313);
        #1;
        chk("mid_grant2", {29'b0, wb.req_ready}, 32'h4);
        push_wr(5'd13, 32'h1313_1313);
        nxt();
        wb.req_valid = 3'b000;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr",   {31'b0, wr_regfile}, 32'h0);
        chk("mid_rst_haz",  {31'b0, hazard}, 32'h0);
        chk("mid_rst_done", {31'b0, init_done}, 32'h0);
        nxt();
        rst = 1'b0;
        push_at(1, 5'd2, 32'h0000ff00);
        push_at(2, 5'd8, 32'h0000ff00);
        repeat (3) nxt();
        chk("mid_init_done", {31'b0, init_done}, 32'h1);
        chk("mid_busy_clr",  {31'b0, hazard}, 32'h0);

        repeat (3) nxt();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_seq.md
REGFILE_WB_SEQ -- requirements
Module: regfile_wb_seq

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of writeback requesters.
REQ-002 The block SHALL have parameter SP_INIT, default 32'hff00, giving the stack pointer (x2) init value.
REQ-003 The block SHALL have parameter BP_INIT, default 32'hff00, giving the base pointer (x8) init value.
REQ-004 CLK  input  1  clock; all state updates on posedge.
REQ-005 RST_X  input  1  reset RST_X, asynchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester writeback request.
REQ-007 req_rd  input  5*NREQ  per-requester destination register.
REQ-008 req_data  input  32*NREQ  per-requester write data.
REQ-009 req_ready  output  NREQ  per-requester grant; transfer occurs when valid&ready.
REQ-010 iss_valid  input  1  instruction issued that will write iss_rd.
REQ-011 iss_rd  input  5  destination of the issued instruction.
REQ-012 q_rs1, q_rs2  input  5 each  source registers to hazard-check.
REQ-013 hazard  output  1  q_rs1 or q_rs2 has a pending write.
REQ-014 wr_regfile  output  1  register file write enable.
REQ-015 wr_regfile_data  output  32  register file write data.
REQ-016 rd  output  5  register file write address.
REQ-017 init_done  output  1  high once the init sequence completes.

Function
REQ-018 FSM states: INIT_SP, INIT_BP, RUN; reset enters INIT_SP.
REQ-019 INIT_SP: the block SHALL register wr_regfile=1, rd=2, data=SP_INIT, then go to INIT_BP next cycle.
REQ-020 INIT_BP: the block SHALL register wr_regfile=1, rd=8, data=BP_INIT, then go to RUN; init_done rises on RUN entry.
REQ-021 req_ready SHALL be all-zero outside RUN.
REQ-022 In RUN, at most one req_ready bit SHALL be high per cycle, chosen round-robin among valid requesters starting after the last granted index; the pointer resets to index 0 priority.
REQ-023 req_ready SHALL be combinational from req_valid and the pointer, and is never asserted for a non-valid requester.
REQ-024 A granted transfer SHALL appear on wr_regfile/rd/wr_regfile_data exactly one cycle later (registered), held for one cycle only.
REQ-025 A granted transfer with rd=0 SHALL be accepted but produce wr_regfile=0.
REQ-026 With no grant, wr_regfile SHALL be 0; rd and wr_regfile_data hold their last values.
REQ-027 Scoreboard busy[31:0]: iss_valid with iss_rd!=0 sets busy[iss_rd]; a granted transfer clears busy[req_rd] of the winner.
REQ-028 A same-cycle set and clear of one register SHALL leave busy set (issue wins).
REQ-029 busy[0] SHALL be constant 0; iss_valid is ignored outside RUN.
REQ-030 hazard SHALL equal busy[q_rs1]|busy[q_rs2], combinational, with no bypass of same-cycle grants.
REQ-031 Two requesters targeting the same rd SHALL both be written, in grant order, in successive cycles.

Reset
REQ-032 While RST_X=1: wr_regfile=0, rd=0, wr_regfile_data=0, req_ready=0, hazard=0, init_done=0, busy=0, pointer=0, state=INIT_SP.
REQ-033 Reset mid-operation SHALL drop any registered pending write (no write in the cycle after release) and restart the init sequence.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the x2/x8 register index constants, and the register-index width (5).
REQ-035 The round-robin arbiter SHALL be a sub-module rr_arbiter (parameter N; inputs req, update; outputs one-hot grant).

Verification
REQ-036 Release reset -> cycle 1: write x2=0000ff00; cycle 2: write x8=0000ff00; init_done=1 in cycle 3; req_ready=0 throughout.
REQ-037 In RUN, all 3 valid continuously (rd=5,6,7) -> grants 0,1,2,0,... one per cycle; writes to 5,6,7 appear one cycle after each grant.
REQ-038 iss_valid rd=9, q_rs1=9 -> hazard=1 next cycle; requester 1 writes rd=9 -> hazard=0 the cycle after the grant.
REQ-039 Same cycle: iss_rd=4 and a grant for rd=4 with busy[4]=1 -> busy[4] stays 1, hazard on q_rs2=4 remains 1.
REQ-040 Grant with rd=0, data=deadbeef -> req_ready pulses, wr_regfile stays 0; iss_rd=0 never raises hazard.
REQ-041 Assert RST_X the cycle after a grant -> no write emitted, busy cleared, the x2/x8 init writes repeat after release.
